sum_feed: RTL and testbench
===========================

# sum_feed

Upstream operand sequencer for the `sum` adder stage. Accepts a burst of 16-bit unsigned operands on a valid/ready stream and drives the adder's `a`/`b`/`start` ports one addition at a time, feeding each result back as the next `a`. Returns the 16-bit wrap-around total of the burst, plus a sticky carry flag, on a valid/ready result port. It is the only block that issues `start` to `sum`.

## Interface

Parameters:
- `WIDTH`, 16: operand and result width; must match the adder.
- `TO_CYCLES`, 15: watchdog limit in cycles per adder wait phase. Used only when `SUM_FEED_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset; 0 resets all state immediately
- `in_valid`  in  1  operand present
- `in_ready`  out  1  operand accepted when `in_valid && in_ready` at a rising edge
- `in_data`  in  WIDTH  operand
- `in_last`  in  1  marks the final operand of a burst
- `add_a`  out  WIDTH  to `sum.a`; the running accumulator
- `add_b`  out  WIDTH  to `sum.b`; the current operand
- `add_start`  out  1  to `sum.start`; one-cycle pulse
- `add_busy`  in  1  from `sum.busy`
- `add_y`  in  WIDTH  from `sum.y`
- `out_valid`  out  1  result present
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_data`  out  WIDTH  burst total, modulo 2^WIDTH
- `out_carry`  out  1  set if any addition in the burst wrapped
- `out_err`  out  1  watchdog fired during the burst; constant 0 when the macro is absent

## Operation

The state machine has six states: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO and DONE.
- **IDLE:** `in_ready`=1.
  - On accept: acc←`in_data`, carry←0, err←0.
  - If `in_last` is set, go to DONE; no adder operation is issued. Otherwise go to FETCH.
- **FETCH:** `in_ready`=1.
  - On accept: opnd←`in_data`, last←`in_last`, go to ISSUE.
- **ISSUE:** `add_start`=1 for exactly this cycle, then go to WAIT_HI.
- **WAIT_HI:** wait for `add_busy`=1, then go to WAIT_LO.
- **WAIT_LO:** wait for `add_busy`=0. Then:
  - acc←`add_y`.
  - carry←carry | (`add_y` < acc_old).
  - Go to DONE if last is set, otherwise go to FETCH.
- **DONE:** `out_valid`=1, with `out_data`/`out_carry`/`out_err` held stable. When `out_ready` is sampled high, go to IDLE.
- `add_a`/`add_b` are driven from the acc/opnd registers. They are stable from ISSUE through WAIT_LO.
- `add_start` is never asserted outside ISSUE. The adder's `ready` output is not used; `busy` is the sole completion indication.
- `in_ready` is 0 in ISSUE, WAIT_HI, WAIT_LO and DONE. Operands are not buffered.
- `out_valid` and `in_ready` are never high in the same cycle.

## Timing

- **Reset values:** state=IDLE, acc=opnd=0, `add_a`=`add_b`=0, `add_start`=0, `in_ready`=0 while `rst`=0, `out_valid`=0, `out_data`=0, `out_carry`=0, `out_err`=0. `in_ready` rises on the first edge after release (IDLE).
- **Per addition:** ISSUE at cycle t. Adder busy at t+1. `add_busy`=0 and `add_y` valid at t+2; acc is captured at the end of t+2. FETCH→ISSUE adds 1 cycle, giving 4 cycles per operand after the first.
- **Burst latency:** a burst of N≥2 operands presented back-to-back reaches `out_valid` 4·(N−1)+1 cycles after the first accept.
- **Single-operand burst:** `out_valid` one cycle after the accept.
- **Back-pressure:** `out_ready` low holds DONE indefinitely.
- **Result handshake:** `out_valid` drops the cycle after the handshake; a new burst may be accepted in that same IDLE cycle.
- **Reset mid-operation:** the FSM aborts immediately, `add_start` drops asynchronously, and partial sums are discarded.

## Configuration

`SUM_FEED_TIMEOUT_EN`:
- **Defined:**
  - A counter clears on entry to WAIT_HI and WAIT_LO, and increments each cycle spent there.
  - Reaching `TO_CYCLES` forces DONE with err=1 and `out_data`=acc as it was before the stalled addition. The remaining operands of the burst are not consumed by the block.
- **Undefined:** no counter is built, `out_err` is tied to 0, and the waits are unbounded.

## Structure

- Shared package `sum_pkg`:
  - `SUM_WIDTH`=16.
  - The state enum `sum_feed_state_t` (IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, DONE).
  - The default `SUM_FEED_TO_CYCLES`=15.
- The watchdog is the one natural sub-module: `sum_feed_wdog` (clear, enable, limit → expired). It is instantiated only under `SUM_FEED_TIMEOUT_EN`.
- The bench instantiates `sum_feed` + `sum` together and, separately, `sum_feed` with a behavioural adder model.

## Test plan

- **Three-operand burst:** burst 3, 5, 7 (`in_last` on 7) with `out_ready`=1 → `out_data`=15, `out_carry`=0, `out_valid` 9 cycles after the first accept, and exactly two `add_start` pulses.
- **Single operand:** single operand 0x1234 with `in_last` → `out_data`=0x1234, no `add_start`, `out_valid` 1 cycle after the accept.
- **Wrap-around:** 0xFFFF then 0x0002 (last) → `out_data`=0x0001, `out_carry`=1. The next burst 1, 1 → `out_carry`=0.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `out_data` and `in_ready`=0 are stable throughout. After the handshake, `out_valid` is 0 the next cycle and a new operand is accepted.
- **Reset mid-operation:** assert `rst`=0 during WAIT_HI → all outputs are at reset values asynchronously. After release, a burst 4, 4 → `out_data`=8.
- **Watchdog (with `SUM_FEED_TIMEOUT_EN`):** the model adder never raises busy, burst 10, 20 → `out_valid` with `out_err`=1 and `out_data`=10, 15 cycles after WAIT_HI is entered.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared definitions for the sum adder stage and its operand sequencer
// (sum_feed): datapath width, sequencer state encoding and watchdog default.
package sum_pkg;

  localparam int SUM_WIDTH          = 16;
  localparam int SUM_FEED_TO_CYCLES = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } sum_feed_state_t;

  // True for the two states in which the sequencer waits on the adder.
  function automatic logic is_wait(input sum_feed_state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/sum_feed_if.sv
// Bundle of the sum_feed streams: operand input, adder drive/return and
// result output. The slave modport is the sequencer's view, the master
// modport is the surrounding environment (producer, adder, consumer).
interface sum_feed_if #(
  parameter int WIDTH = sum_pkg::SUM_WIDTH
);

  // Operand stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // Adder drive and return
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_start;
  logic             add_busy;
  logic [WIDTH-1:0] add_y;

  // Result stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output add_a, add_b, add_start,
    input  add_busy, add_y,
    output out_valid, out_data, out_carry, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  add_a, add_b, add_start,
    output add_busy, add_y,
    input  out_valid, out_data, out_carry, out_err,
    output out_ready
  );

endinterface

// File: rtl/sum_feed_wdog.sv
// Wait-phase watchdog for sum_feed (built only with SUM_FEED_TIMEOUT_EN).
// The count restarts on i_clear and advances on every enabled cycle;
// o_expired flags the LIMIT-th consecutive enabled cycle of a wait phase.
module sum_feed_wdog
  import sum_pkg::*;
#(
  parameter int LIMIT = SUM_FEED_TO_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == CW'(LIMIT - 1));

  // Cycle counter: clear has priority, saturates at the expiry value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sum_feed.sv
// sum_feed: operand sequencer in front of the sum adder. Accumulates a burst
// of operands one addition at a time (result fed back as the next a input)
// and returns the wrap-around total with a sticky carry.
// Optional build macro SUM_FEED_TIMEOUT_EN adds a per-wait-phase watchdog
// that aborts a stalled burst with out_err set; without it out_err is 0.
module sum_feed
  import sum_pkg::*;
#(
  parameter int WIDTH     = SUM_WIDTH,
  parameter int TO_CYCLES = SUM_FEED_TO_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  sum_feed_if.slave bus
);

  if (TO_CYCLES < 1) begin : g_bad_to_cycles
    $error("sum_feed: TO_CYCLES must be at least 1");
  end

  sum_feed_state_t  r_state;
  sum_feed_state_t  w_next;
  logic             r_live;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_last;
  logic             r_carry;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_expired;

  // r_live keeps in_ready low until the first edge after reset release.
  assign w_in_ready = r_live && ((r_state == IDLE) || (r_state == FETCH));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_capture  = (r_state == WAIT_LO) && !bus.add_busy;

  assign bus.in_ready  = w_in_ready;
  assign bus.add_a     = r_acc;
  assign bus.add_b     = r_opnd;
  assign bus.add_start = (r_state == ISSUE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_acc;
  assign bus.out_carry = r_carry;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from the pre-edge values; blocking here would
  // make results depend on statement and process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; adder progress takes priority over watchdog expiry.
  // NOTE: w_next is given a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = bus.in_last ? DONE : FETCH;
      end
      FETCH: begin
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        w_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.add_busy)   w_next = WAIT_LO;
        else if (w_expired) w_next = DONE;
      end
      WAIT_LO: begin
        if (!bus.add_busy)  w_next = r_last ? DONE : FETCH;
        else if (w_expired) w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: first operand seeds acc, later ones go to opnd, sums fold back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_last  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if ((r_state == IDLE) && w_accept) begin
        r_acc   <= bus.in_data;
        r_carry <= 1'b0;
      end
      if ((r_state == FETCH) && w_accept) begin
        r_opnd <= bus.in_data;
        r_last <= bus.in_last;
      end
      if (w_capture) begin
        r_acc   <= bus.add_y;
        r_carry <= r_carry | (bus.add_y < r_acc);
      end
    end
  end

`ifdef SUM_FEED_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_en;
  logic w_to_fire;
  logic r_err;

  assign w_wd_en    = is_wait(r_state);
  assign w_wd_clear = (w_next != r_state) && is_wait(w_next);
  // Expiry only aborts when the adder made no progress this cycle.
  assign w_to_fire  = w_expired &&
                      (((r_state == WAIT_HI) && !bus.add_busy) ||
                       ((r_state == WAIT_LO) &&  bus.add_busy));

  sum_feed_wdog #(
    .LIMIT(TO_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_expired(w_expired)
  );

  // Error flag: cleared by a new burst, set by a watchdog abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && w_accept) begin
      r_err <= 1'b0;
    end else if (w_to_fire) begin
      r_err <= 1'b1;
    end
  end

  assign bus.out_err = r_err;
`else
  assign w_expired   = 1'b0;
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_sum_feed.sv
// Self-checking bench for sum_feed with a behavioural adder model.
// Stimulus pushes the expected burst result into a scoreboard queue; an
// independent monitor pops and compares on every result handshake.
module tb_sum_feed;
  import sum_pkg::*;

  localparam int W = SUM_WIDTH;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         err;
    int           lat;     // cycles first accept -> out_valid, -1 = skip
    int           starts;  // add_start pulses expected in the burst
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rnd_ready = 1'b0;
  bit   want_ready = 1'b1;
  bit   adder_stall = 1'b0;
  exp_t exp_q[$];
  logic [W-1:0] ops_q[$];

  sum_feed_if #(.WIDTH(W)) bus();

  sum_feed #(
    .WIDTH    (W),
    .TO_CYCLES(SUM_FEED_TO_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural adder: busy the cycle after start, result and busy low next.
  initial begin
    logic         s_start, s_busy;
    logic [W-1:0] s_a, s_b, h_a, h_b;
    h_a = '0; h_b = '0;
    bus.add_busy = 1'b0;
    bus.add_y    = '0;
    forever begin
      @(negedge clk);
      s_start = bus.add_start; s_busy = bus.add_busy;
      s_a = bus.add_a; s_b = bus.add_b;
      @(posedge clk); #1;
      if (!rst) begin
        bus.add_busy = 1'b0;
        bus.add_y    = '0;
      end else if (s_start && !adder_stall) begin
        bus.add_busy = 1'b1;
        h_a = s_a; h_b = s_b;
      end else if (s_busy) begin
        bus.add_busy = 1'b0;
        bus.add_y    = h_a + h_b;
      end
    end
  end

  // Result consumer: random or fixed readiness.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : want_ready;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int   acc_cyc, starts, lat;
    bit   in_burst, prev_ov;
    exp_t e;
    acc_cyc = 0; starts = 0; lat = -1; in_burst = 0; prev_ov = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_burst = 0; starts = 0; lat = -1; prev_ov = 0;
      end else begin
        if (bus.in_valid && bus.in_ready && !in_burst) begin
          in_burst = 1; acc_cyc = cyc; starts = 0;
        end
        if (bus.add_start) starts++;
        if (bus.out_valid) begin
          check("in_ready_low_in_done", 32'(bus.in_ready), 32'(0));
          if (!prev_ov) lat = cyc - acc_cyc;
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_result: got data 0x%0h, no result expected", bus.out_data);
            end else begin
              e = exp_q.pop_front();
              check("out_data",  32'(bus.out_data),  32'(e.data));
              check("out_carry", 32'(bus.out_carry), 32'(e.carry));
              check("out_err",   32'(bus.out_err),   32'(e.err));
              if (e.lat >= 0) check("latency", 32'(lat), 32'(e.lat));
              check("add_start_count", 32'(starts), 32'(e.starts));
            end
            in_burst = 0;
          end
        end
        prev_ov = bus.out_valid && !bus.out_ready;
      end
    end
  end

  task automatic send_op(input logic [W-1:0] d, input logic l);
    int k = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && k < 300) begin @(negedge clk); k++; end
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_wait: operand 0x%0h not accepted within 300 cycles", d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  // Reference: plain modular sum; carry if any partial sum exceeded 2^W-1.
  task automatic run_burst(input bit gaps, input bit stalled);
    exp_t e;
    int   n = ops_q.size();
    int   acc = int'(ops_q[0]);
    int   s;
    e.carry = 1'b0;
    for (int i = 1; i < n; i++) begin
      s = acc + int'(ops_q[i]);
      if (s >= (1 << W)) e.carry = 1'b1;
      acc = s % (1 << W);
    end
    e.data   = W'(acc);
    e.err    = 1'b0;
    e.starts = n - 1;
    e.lat    = gaps ? -1 : ((n == 1) ? 1 : 4 * (n - 1) + 1);
    if (stalled) begin
      // Watchdog abort on the first addition: total is the first operand.
      e.data = ops_q[0]; e.carry = 1'b0; e.err = 1'b1;
      e.starts = 1; e.lat = 3 + SUM_FEED_TO_CYCLES;
    end
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      send_op(ops_q[i], 1'(i == n - 1));
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int k;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;

    // Reset values.
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_data",  32'(bus.out_data),  32'(0));
    check("rst_out_carry", 32'(bus.out_carry), 32'(0));
    check("rst_out_err",   32'(bus.out_err),   32'(0));
    check("rst_add_start", 32'(bus.add_start), 32'(0));
    check("rst_add_a",     32'(bus.add_a),     32'(0));
    check("rst_add_b",     32'(bus.add_b),     32'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 check("in_ready_before_first_edge", 32'(bus.in_ready), 32'(0));
    @(posedge clk); #1;
    check("in_ready_after_first_edge", 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;

    // Three-operand burst, single operand, wrap-around and its follow-up.
    ops_q = '{16'd3, 16'd5, 16'd7};       run_burst(0, 0);
    ops_q = '{16'h1234};                  run_burst(0, 0);
    ops_q = '{16'hFFFF, 16'h0002};        run_burst(0, 0);
    ops_q = '{16'd1, 16'd1};              run_burst(0, 0);
    drain();

    // Back-pressure: DONE held while out_ready is low.
    @(posedge clk); #1; want_ready = 1'b0;
    ops_q = '{16'd9, 16'd8};              run_burst(0, 0);
    k = 0;
    while (!bus.out_valid && k < 50) begin @(negedge clk); k++; end
    check("bp_out_valid_reached", 32'(bus.out_valid), 32'(1));
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid_stable", 32'(bus.out_valid), 32'(1));
      check("bp_out_data_stable",  32'(bus.out_data),  32'(17));
      check("bp_in_ready_low",     32'(bus.in_ready),  32'(0));
    end
    @(posedge clk); #1; want_ready = 1'b1;
    @(posedge clk); #3;
    check("bp_out_valid_dropped", 32'(bus.out_valid), 32'(0));
    check("bp_in_ready_idle",     32'(bus.in_ready),  32'(1));
    ops_q = '{16'd100, 16'd23};           run_burst(0, 0);
    drain();

    // Randomized bursts with random back-pressure and occasional gaps.
    rnd_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      int n = $urandom_range(1, 6);
      ops_q.delete();
      for (int i = 0; i < n; i++)
        ops_q.push_back(($urandom_range(0, 2) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                    : 16'($urandom()));
      run_burst(($urandom_range(0, 3) == 0), 0);
    end
    rnd_ready = 1'b0; want_ready = 1'b1;
    drain();

    // Reset mid-operation (in WAIT_HI): abort and restart.
    @(posedge clk); #1;
    send_op(16'd100, 1'b0);
    send_op(16'd200, 1'b1);
    check("issue_add_start", 32'(bus.add_start), 32'(1));
    check("issue_add_a",     32'(bus.add_a),     32'(100));
    check("issue_add_b",     32'(bus.add_b),     32'(200));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_add_start", 32'(bus.add_start), 32'(0));
    check("midrst_in_ready",  32'(bus.in_ready),  32'(0));
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_out_data",  32'(bus.out_data),  32'(0));
    check("midrst_add_a",     32'(bus.add_a),     32'(0));
    check("midrst_add_b",     32'(bus.add_b),     32'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    ops_q = '{16'd4, 16'd4};              run_burst(0, 0);
    drain();

`ifdef SUM_FEED_TIMEOUT_EN
    // Watchdog: adder never raises busy.
    adder_stall = 1'b1;
    ops_q = '{16'd10, 16'd20};            run_burst(0, 1);
    drain();
    adder_stall = 1'b0;
    ops_q = '{16'd6, 16'd7};              run_burst(0, 0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
